// File: rtl/mmio_port_pkg.sv
// Shared definitions for the memory-mapped port unit: register map,
// STATUS bit positions, default base address and the address decoder.
package mmio_port_pkg;

  // Default byte address of register 0 (DATA_OUT)
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0100;

  // Byte offsets of the three registers from the base address
  localparam logic [3:0] OFF_DATA_OUT = 4'h0;
  localparam logic [3:0] OFF_DATA_IN  = 4'h4;
  localparam logic [3:0] OFF_STATUS   = 4'h8;

  // STATUS register bit positions
  localparam int STAT_EMPTY    = 0;
  localparam int STAT_FULL     = 1;
  localparam int STAT_CHANGED  = 2;
  localparam int STAT_OVERFLOW = 3;

  typedef enum logic [1:0] {
    REG_DATA_OUT,
    REG_DATA_IN,
    REG_STATUS,
    REG_NONE
  } reg_sel_e;

  // Word-granular decode: byte lanes are irrelevant, so only word
  // addresses are compared against the base.
  function automatic reg_sel_e decode_reg(input logic [29:0] word_addr,
                                          input logic [29:0] base_word);
    logic [29:0] off;
    off = word_addr - base_word;
    if (off == 30'(OFF_DATA_OUT >> 2)) return REG_DATA_OUT;
    if (off == 30'(OFF_DATA_IN >> 2))  return REG_DATA_IN;
    if (off == 30'(OFF_STATUS >> 2))   return REG_STATUS;
    return REG_NONE;
  endfunction

endpackage

// File: rtl/port_out_fifo.sv
// Output FIFO for the port unit. The head entry is exposed directly;
// a pop and a push may occur on the same edge even when full.
module port_out_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;

  // A push while full is only taken if the head leaves on the same edge
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Head is forced to zero while empty so stale entries never leak out
  assign head = empty ? '0 : mem_q[rd_ptr_q];

  // Next-state pointers and occupancy; pointers wrap naturally (DEPTH is 2^n)
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count state, cleared immediately on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because empty masks the head
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/mmio_port_unit.sv
// Memory-mapped I/O port: a store-fed output FIFO, a synchronized 8-bit
// input with sticky change detection, and a STATUS register.
module mmio_port_unit
  import mmio_port_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [31:0] ReadData,
  output logic        Hit,
  input  logic [7:0]  PortIn,
  output logic [31:0] PortOut,
  output logic        OutValid,
  input  logic        OutReady
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  reg_sel_e         sel;
  logic             store_data_out, store_status, load_data_in;
  logic             fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [31:0]      fifo_head;
  logic             overflow_evt, change_evt;
  logic [7:0]       sync1_q, sync2_q, prev_q;
  logic             changed_q, changed_d;
  logic             overflow_q, overflow_d;
  logic [31:0]      status_word;
  logic             addr_lsb_unused;

  // Byte-lane bits of the address play no part in decoding
  assign addr_lsb_unused = ^Address[1:0];

  assign sel = decode_reg(Address[31:2], BASE_ADDR[31:2]);
  assign Hit = (sel != REG_NONE);

  assign store_data_out = MemWrite && (sel == REG_DATA_OUT);
  assign store_status   = MemWrite && (sel == REG_STATUS);
  assign load_data_in   = MemRead  && (sel == REG_DATA_IN);

  assign fifo_pop     = OutValid && OutReady;
  assign overflow_evt = store_data_out && fifo_full && !fifo_pop;
  assign change_evt   = (sync2_q != prev_q);

  port_out_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (store_data_out),
    .pop   (fifo_pop),
    .din   (WriteData),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (fifo_head)
  );

  assign OutValid = !fifo_empty;
  assign PortOut  = fifo_head;

  // Sticky flags: a new event on the same edge beats a software clear
  always_comb begin
    overflow_d = overflow_q;
    changed_d  = changed_q;
    if (store_status && WriteData[STAT_OVERFLOW]) overflow_d = 1'b0;
    if (overflow_evt)                             overflow_d = 1'b1;
    if (load_data_in)                             changed_d  = 1'b0;
    if (change_evt)                               changed_d  = 1'b1;
  end

  // Input synchronizer, previous-value copy and sticky flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      changed_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      sync1_q    <= PortIn;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      changed_q  <= changed_d;
      overflow_q <= overflow_d;
    end
  end

  // Combinational load data; zero whenever the address misses this block
  always_comb begin
    status_word                = '0;
    status_word[STAT_EMPTY]    = fifo_empty;
    status_word[STAT_FULL]     = fifo_full;
    status_word[STAT_CHANGED]  = changed_q;
    status_word[STAT_OVERFLOW] = overflow_q;
    case (sel)
      REG_DATA_OUT: ReadData = 32'(fifo_count);
      REG_DATA_IN:  ReadData = {24'b0, sync2_q};
      REG_STATUS:   ReadData = status_word;
      default:      ReadData = '0;
    endcase
  end

endmodule

// File: tb/tb_mmio_port_unit.sv
// Bench for mmio_port_unit: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue-based model.
module tb_mmio_port_unit;

  localparam logic [31:0] BASE  = 32'h1001_0100;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] Address = '0;
  logic [31:0] WriteData = '0;
  logic        MemWrite = 1'b0;
  logic        MemRead = 1'b0;
  logic        OutReady = 1'b0;
  logic [7:0]  PortIn = '0;
  logic [31:0] ReadData;
  logic        Hit;
  logic [31:0] PortOut;
  logic        OutValid;

  always #5 clk = ~clk;

  mmio_port_unit #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .Address   (Address),
    .WriteData (WriteData),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .ReadData  (ReadData),
    .Hit       (Hit),
    .PortIn    (PortIn),
    .PortOut   (PortOut),
    .OutValid  (OutValid),
    .OutReady  (OutReady)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mq[$];        // FIFO contents, head at index 0
  bit          m_ovf, m_chg;
  logic [7:0]  m_hist [3];   // PortIn sampled at the last three edges, [0] newest

  // Register index addressed: 0 DATA_OUT, 1 DATA_IN, 2 STATUS, -1 none
  function automatic int m_reg(input logic [31:0] a);
    logic [31:0] aa;
    aa = {a[31:2], 2'b00};
    if (aa == BASE)          return 0;
    if (aa == BASE + 32'd4)  return 1;
    if (aa == BASE + 32'd8)  return 2;
    return -1;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    int r;
    int sz;
    r  = m_reg(a);
    sz = mq.size();
    case (r)
      0:       return 32'(sz);
      1:       return {24'b0, m_hist[1]};
      2:       return (m_ovf ? 32'd8 : 32'd0) + (m_chg ? 32'd4 : 32'd0) +
                      ((sz == DEPTH) ? 32'd2 : 32'd0) + ((sz == 0) ? 32'd1 : 32'd0);
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_ovf = 1'b0;
      m_chg = 1'b0;
      m_hist = '{8'h00, 8'h00, 8'h00};
    end else begin : model_step
      int r;
      bit pop, accept, chg_evt, ovf_evt, ovf_clr, chg_clr;
      r       = m_reg(Address);
      pop     = (mq.size() > 0) && OutReady;
      accept  = (mq.size() < DEPTH) || pop;
      chg_evt = (m_hist[1] != m_hist[2]);
      ovf_evt = (r == 0) && MemWrite && !accept;
      ovf_clr = (r == 2) && MemWrite && WriteData[3];
      chg_clr = (r == 1) && MemRead;
      if (pop) void'(mq.pop_front());
      if ((r == 0) && MemWrite && accept) mq.push_back(WriteData);
      if (ovf_evt)      m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
      if (chg_evt)      m_chg = 1'b1;
      else if (chg_clr) m_chg = 1'b0;
      m_hist[2] = m_hist[1];
      m_hist[1] = m_hist[0];
      m_hist[0] = PortIn;
    end
  end

  // Every-cycle comparison, away from the active edge
  always @(negedge clk) begin
    if (!reset) begin
      check("OutValid", {31'b0, OutValid}, {31'b0, (mq.size() != 0)});
      check("PortOut", PortOut, (mq.size() != 0) ? mq[0] : 32'd0);
      check("Hit", {31'b0, Hit}, {31'b0, (m_reg(Address) >= 0)});
      check("ReadData", ReadData, m_read(Address));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic store(input logic [31:0] off, input logic [31:0] data);
    Address   = BASE + off;
    WriteData = data;
    MemWrite  = 1'b1;
    cyc();
    MemWrite  = 1'b0;
  endtask

  task automatic check_rd(input string name, input logic [31:0] off, input logic [31:0] exp);
    Address = BASE + off;
    #1;
    check(name, ReadData, exp);
  endtask

  logic [31:0] last;

  initial begin
    // Reset state
    #1 reset = 1'b1;
    Address = BASE + 32'd8;
    #1;
    check("rst_outvalid", {31'b0, OutValid}, 32'd0);
    check("rst_portout", PortOut, 32'd0);
    check("rst_status", ReadData, 32'h1);
    cyc();
    reset = 1'b0;
    cyc();

    // Single entry held until accepted
    OutReady = 1'b0;
    store(32'h0, 32'hA5);
    check("a5_valid", {31'b0, OutValid}, 32'd1);
    check("a5_data", PortOut, 32'h0000_00A5);
    cyc();
    cyc();
    check("a5_hold_valid", {31'b0, OutValid}, 32'd1);
    check("a5_hold_data", PortOut, 32'h0000_00A5);
    OutReady = 1'b1;
    cyc();
    OutReady = 1'b0;
    check("a5_popped", {31'b0, OutValid}, 32'd0);

    // Overflow on fifth store, ordered drain, overflow clear
    for (int i = 1; i <= 5; i++) store(32'h0, 32'(i));
    check_rd("ovf_count", 32'h0, 32'd4);
    check_rd("ovf_status", 32'h8, 32'h0000_000A);
    OutReady = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("drain_%0d", i), PortOut, 32'(i));
      cyc();
    end
    OutReady = 1'b0;
    check("drain_empty", {31'b0, OutValid}, 32'd0);
    store(32'h8, 32'h8);
    check_rd("ovf_cleared", 32'h8, 32'h1);

    // Push and pop together while full
    for (int i = 1; i <= 4; i++) store(32'h0, 32'(i));
    OutReady = 1'b1;
    store(32'h0, 32'd9);
    OutReady = 1'b0;
    check_rd("pp_count", 32'h0, 32'd4);
    check_rd("pp_status", 32'h8, 32'h2);
    OutReady = 1'b1;
    last = '0;
    for (int i = 0; i < 4; i++) begin
      last = PortOut;
      cyc();
    end
    OutReady = 1'b0;
    check("pp_last", last, 32'd9);

    // Input synchronizer and CHANGED flag
    PortIn = 8'h3C;
    Address = BASE + 32'h4;
    cyc();
    check_rd("din_edge1", 32'h4, 32'h0);
    cyc();
    check_rd("din_edge2", 32'h4, 32'h3C);
    check_rd("chg_edge2", 32'h8, 32'h1);
    cyc();
    check_rd("chg_edge3", 32'h8, 32'h5);
    Address = BASE + 32'h4;
    MemRead = 1'b1;
    cyc();
    MemRead = 1'b0;
    check_rd("chg_cleared", 32'h8, 32'h1);

    // Asynchronous reset with entries queued and CHANGED set
    store(32'h0, 32'h11);
    store(32'h0, 32'h22);
    store(32'h0, 32'h33);
    PortIn = 8'h55;
    cyc();
    cyc();
    cyc();
    check_rd("prerst_status", 32'h8, 32'h4);
    reset = 1'b1;
    #1;
    check("arst_outvalid", {31'b0, OutValid}, 32'd0);
    check("arst_portout", PortOut, 32'd0);
    check("arst_status", ReadData, 32'h1);
    cyc();
    reset = 1'b0;
    store(32'h0, 32'h77);
    check("post_rst_valid", {31'b0, OutValid}, 32'd1);
    check("post_rst_data", PortOut, 32'h77);
    OutReady = 1'b1;
    cyc();
    OutReady = 1'b0;

    // Load just past the register map
    Address = BASE + 32'hC;
    MemRead = 1'b1;
    #1;
    check("miss_hit", {31'b0, Hit}, 32'd0);
    check("miss_data", ReadData, 32'd0);
    cyc();
    MemRead = 1'b0;
    check_rd("miss_count", 32'h0, 32'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      int pick;
      pick = int'($urandom_range(0, 4));
      case (pick)
        0: Address = BASE;
        1: Address = BASE + 32'h4;
        2: Address = BASE + 32'h8;
        3: Address = BASE + 32'hC;
        default: Address = $urandom;
      endcase
      Address[1:0] = 2'($urandom_range(0, 3));
      MemWrite  = ($urandom_range(0, 99) < 40);
      MemRead   = ($urandom_range(0, 99) < 30);
      WriteData = $urandom;
      OutReady  = ($urandom_range(0, 99) < 45);
      if ($urandom_range(0, 9) == 0) PortIn = 8'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
      end
      cyc();
    end
    MemWrite = 1'b0;
    MemRead  = 1'b0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
